// File: rtl/encrypt_ctrl_pkg.sv
// Shared types and helpers for the LWE encryption accumulator sequencer.
package encrypt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_CLEAR
  } state_t;

  localparam int MAX_WIDTH = 64;

  // All-ones pattern of the requested width; callers cast it down to their lane width.
  function automatic logic [MAX_WIDTH-1:0] mask_f(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
  endfunction

  function automatic int beats_f(input int big_n, input int parallel);
    return (big_n + 2 * parallel - 1) / (2 * parallel);
  endfunction

endpackage

// File: rtl/encrypt_ctrl_if.sv
// Term stream in, accumulator operand bus and ciphertext strobe out.
interface encrypt_ctrl_if #(
  parameter int CIPHERTEXT_WIDTH = 32,
  parameter int PARALLEL         = 2,
  parameter int DIM_WIDTH        = 7
);

  logic                                    in_valid;
  logic                                    in_ready;
  logic [2*PARALLEL*CIPHERTEXT_WIDTH-1:0]  in_data;
  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]    dp_op1;
  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]    dp_op2;
  logic [DIM_WIDTH-1:0]                    dp_row;
  logic                                    dp_done;
  logic                                    ct_valid;
  logic [DIM_WIDTH-1:0]                    ct_row;

  modport master (
    input  in_valid, in_data,
    output in_ready, dp_op1, dp_op2, dp_row, dp_done, ct_valid, ct_row
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, dp_op1, dp_op2, dp_row, dp_done, ct_valid, ct_row
  );

endinterface

// File: rtl/encrypt_ctrl_pack.sv
// Splits one term beat into the two operand buses, masking terms past BIG_N on the last beat.
module encrypt_ctrl_pack
  import encrypt_ctrl_pkg::*;
#(
  parameter int CIPHERTEXT_WIDTH = 32,
  parameter int BIG_N            = 30,
  parameter int PARALLEL         = 2,
  parameter int BEAT_W           = 3
) (
  input  logic [BEAT_W-1:0]                       beat,
  input  logic [2*PARALLEL*CIPHERTEXT_WIDTH-1:0]  in_data,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]    op1,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0]    op2
);

  localparam int CW = CIPHERTEXT_WIDTH;
  localparam logic [CW-1:0] MASK = CW'(mask_f(CW));

  logic [CW-1:0] lane [2*PARALLEL];

  // Terms with MSB already set are passed untouched; the accumulator ignores them itself.
  always_comb begin
    for (int k = 0; k < 2 * PARALLEL; k++) begin
      if (int'(beat) * (2 * PARALLEL) + k >= BIG_N) lane[k] = MASK;
      else                                          lane[k] = in_data[k*CW +: CW];
    end
  end

  for (genvar k = 0; k < PARALLEL; k++) begin : g_lane
    assign op1[k*CW +: CW] = lane[k];
    assign op2[k*CW +: CW] = lane[PARALLEL + k];
  end

endmodule

// File: rtl/encrypt_ctrl.sv
// Encryption accumulator sequencer: FSM, beat/row counters and ciphertext strobe pipeline.
// Optional stall counter built when ENCRYPT_CTRL_PERF_EN is defined.
module encrypt_ctrl
  import encrypt_ctrl_pkg::*;
#(
  parameter int CIPHERTEXT_WIDTH = 32,
  parameter int DIMENSION        = 128,
  parameter int DIM_WIDTH        = 7,
  parameter int BIG_N            = 30,
  parameter int PARALLEL         = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic [31:0]          stall_cycles,
  encrypt_ctrl_if.master       bus
);

  localparam int CW     = CIPHERTEXT_WIDTH;
  localparam int OPW    = PARALLEL * CW;
  localparam int BEATS  = beats_f(BIG_N, PARALLEL);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]  MASK    = CW'(mask_f(CW));
  localparam logic [OPW-1:0] OP_MASK = {PARALLEL{MASK}};

  state_t               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [DIM_WIDTH-1:0] row_q, row_d;
  logic [OPW-1:0]       op1_q, op1_d, op2_q, op2_d;
  logic [OPW-1:0]       pack_op1, pack_op2;
  logic [DIM_WIDTH-1:0] dp_row_q, dp_row_d;
  logic                 dp_done_q, dp_done_d;
  logic                 aborted_q, aborted_d;
  logic                 pend_q, pend_d;
  logic [DIM_WIDTH-1:0] pend_row_q, pend_row_d;
  logic                 ct_valid_q;
  logic [DIM_WIDTH-1:0] ct_row_q;

  encrypt_ctrl_pack #(
    .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH),
    .BIG_N            (BIG_N),
    .PARALLEL         (PARALLEL),
    .BEAT_W           (BEAT_W)
  ) u_pack (
    .beat    (beat_q),
    .in_data (bus.in_data),
    .op1     (pack_op1),
    .op2     (pack_op2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of every registered output; ops idle at MASK unless a beat lands.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    row_d      = row_q;
    op1_d      = OP_MASK;
    op2_d      = OP_MASK;
    dp_row_d   = dp_row_q;
    dp_done_d  = dp_done_q;
    aborted_d  = aborted_q;
    case (state_q)
      ST_IDLE: begin
        dp_done_d = 1'b1;
        dp_row_d  = '0;
        if (start) begin
          state_d   = ST_LOAD;
          beat_d    = '0;
          row_d     = '0;
          aborted_d = 1'b0;
        end
      end
      ST_LOAD: begin
        dp_done_d = 1'b0;
        if (abort) begin
          state_d   = ST_CLEAR;
          aborted_d = 1'b1;
        end else if (bus.in_valid) begin
          op1_d    = pack_op1;
          op2_d    = pack_op2;
          dp_row_d = row_q;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            beat_d = '0;
            row_d  = row_q + 1'b1;
            if (row_q == DIM_WIDTH'(DIMENSION - 1)) state_d = ST_FLUSH;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        dp_row_d = '0;
        state_d  = ST_CLEAR;
      end
      ST_CLEAR: begin
        dp_done_d = 1'b1;
        dp_row_d  = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The row reset done by CLEAR after an abort carries no finished ciphertext.
    pend_d     = (dp_row_d != dp_row_q) && !(state_q == ST_CLEAR && aborted_q);
    pend_row_d = dp_row_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      row_q      <= '0;
      op1_q      <= OP_MASK;
      op2_q      <= OP_MASK;
      dp_row_q   <= '0;
      dp_done_q  <= 1'b1;
      aborted_q  <= 1'b0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      ct_valid_q <= 1'b0;
      ct_row_q   <= '0;
    end else begin
      beat_q     <= beat_d;
      row_q      <= row_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      dp_row_q   <= dp_row_d;
      dp_done_q  <= dp_done_d;
      aborted_q  <= aborted_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      ct_valid_q <= pend_q;
      ct_row_q   <= pend_q ? pend_row_q : ct_row_q;
    end
  end

`ifdef ENCRYPT_CTRL_PERF_EN
  logic [31:0] stall_q;

  // Counts LOAD cycles starved of input; saturates and restarts with each accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         stall_q <= '0;
    else if (state_q == ST_IDLE && start)               stall_q <= '0;
    else if (state_q == ST_LOAD && !bus.in_valid && stall_q != '1)
                                                        stall_q <= stall_q + 1'b1;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

  assign busy         = (state_q != ST_IDLE);
  assign bus.in_ready = (state_q == ST_LOAD);
  assign bus.dp_op1   = op1_q;
  assign bus.dp_op2   = op2_q;
  assign bus.dp_row   = dp_row_q;
  assign bus.dp_done  = dp_done_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.ct_row   = ct_row_q;

endmodule
